// File: rtl/mu0_mem_pkg.sv
// Shared types and widths for the MU0 memory arbiter.
package mu0_mem_pkg;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 16;

    typedef enum logic {
        PORT_FETCH,
        PORT_DATA
    } port_t;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

endpackage

// File: rtl/mu0_rr_arb2.sv
// Two-way round-robin grant for the fetch and data ports.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   en_i                         grants allowed this cycle
//   req_fetch_i, req_data_i      requests
//   gnt_fetch_o, gnt_data_o      one-hot (or zero) grants, combinational
module mu0_rr_arb2
    import mu0_mem_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic req_fetch_i,
    input  logic req_data_i,
    output logic gnt_fetch_o,
    output logic gnt_data_o
);

    port_t last_grant_q, last_grant_d;

    always_comb begin
        gnt_fetch_o  = 1'b0;
        gnt_data_o   = 1'b0;
        last_grant_d = last_grant_q;
        if (en_i) begin
            if (req_fetch_i && req_data_i) begin
                // Under contention the port that did not win last time goes next.
                gnt_fetch_o = (last_grant_q == PORT_DATA);
                gnt_data_o  = (last_grant_q == PORT_FETCH);
            end else begin
                gnt_fetch_o = req_fetch_i;
                gnt_data_o  = req_data_i;
            end
        end
        if (gnt_fetch_o) begin
            last_grant_d = PORT_FETCH;
        end else if (gnt_data_o) begin
            last_grant_d = PORT_DATA;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= PORT_DATA;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/mu0_mem_arbiter.sv
// Merges the MU0 fetch port (read-only) and data port (read/write) onto the
// single-ported 16x4096 RAM. Read data returns as a registered, held value
// with a one-cycle rvalid pulse on the requesting port.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   i_req/i_addr -> i_gnt/i_rvalid/i_rdata           fetch port
//   d_req/d_we/d_addr/d_wdata -> d_gnt/d_rvalid/d_rdata  data port
//   ram_address/ram_read/ram_write/ram_writedata -> RAM, ram_readdata <- RAM
// READ_LATENCY: 0 = combinational RAM readdata, 1 = registered at issue edge.
module mu0_mem_arbiter
    import mu0_mem_pkg::*;
#(
    parameter int READ_LATENCY = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_read,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    input  logic [DATA_W-1:0] ram_readdata
);

    if (READ_LATENCY != 0 && READ_LATENCY != 1) begin : g_bad_latency
        $error("mu0_mem_arbiter: READ_LATENCY must be 0 or 1");
    end

    state_t            state_q, state_d;
    port_t             pending_q, pending_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              i_rvalid_q, i_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              arb_en;
    logic              rd_gnt;

    // Reset gates the enable so no grant or RAM strobe escapes while held.
    assign arb_en = (state_q == ST_IDLE) && rst_n;

    mu0_rr_arb2 u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (arb_en),
        .req_fetch_i (i_req),
        .req_data_i  (d_req),
        .gnt_fetch_o (i_gnt),
        .gnt_data_o  (d_gnt)
    );

    always_comb begin
        ram_address   = addr_q;
        ram_writedata = wdata_q;
        ram_read      = 1'b0;
        ram_write     = 1'b0;
        if (i_gnt) begin
            ram_address = i_addr;
            ram_read    = 1'b1;
        end else if (d_gnt) begin
            ram_address   = d_addr;
            ram_writedata = d_wdata;
            ram_write     = d_we;
            ram_read      = !d_we;
        end
    end

    assign rd_gnt = ram_read;

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        i_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;

        if (i_gnt || d_gnt) begin
            addr_d  = ram_address;
            wdata_d = ram_writedata;
        end
        if (rd_gnt) begin
            pending_d = i_gnt ? PORT_FETCH : PORT_DATA;
        end

        if (READ_LATENCY == 0) begin
            if (i_gnt) begin
                i_rdata_d  = ram_readdata;
                i_rvalid_d = 1'b1;
            end else if (rd_gnt) begin
                d_rdata_d  = ram_readdata;
                d_rvalid_d = 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rd_gnt) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    state_d = ST_IDLE;
                    if (pending_q == PORT_FETCH) begin
                        i_rdata_d  = ram_readdata;
                        i_rvalid_d = 1'b1;
                    end else begin
                        d_rdata_d  = ram_readdata;
                        d_rvalid_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pending_q  <= PORT_FETCH;
            addr_q     <= '0;
            wdata_q    <= '0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            i_rvalid_q <= i_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign i_rvalid = i_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign i_rdata  = i_rdata_q;
    assign d_rdata  = d_rdata_q;

endmodule

// File: doc/mu0_mem_arbiter.md
Name: mu0_mem_arbiter

Overview:
- Two-port arbiter that sits directly upstream of the shared 16x4096 MU0 RAM.
- Merges the instruction-fetch port (read-only) and the data port (read/write) onto the RAM's single address/read/write interface.
- Handles both RAM read timings (combinational and 1-cycle registered) and returns read data to the requesting port as a registered, held response with a valid pulse.

Parameters:
READ_LATENCY, 0, RAM read timing: 0 = combinational readdata, 1 = readdata registered at the issuing edge. Any other value raises an elaboration $error.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset; one clock; reset is asynchronous and active-low
i_req  input  1  fetch port read request
i_addr  input  12  fetch address
i_gnt  output  1  fetch request accepted this cycle
i_rvalid  output  1  one-cycle pulse: i_rdata updated
i_rdata  output  16  last fetch read data, held
d_req  input  1  data port request
d_we  input  1  1 = write, 0 = read
d_addr  input  12  data address
d_wdata  input  16  write data
d_gnt  output  1  data request accepted this cycle
d_rvalid  output  1  one-cycle pulse: d_rdata updated (reads only)
d_rdata  output  16  last data read data, held
ram_address  output  12  to RAM address
ram_read  output  1  to RAM read
ram_write  output  1  to RAM write
ram_writedata  output  16  to RAM writedata
ram_readdata  input  16  from RAM readdata

Behaviour:
- Async reset (rst_n low):
  - state=ST_IDLE; last_grant=PORT_DATA.
  - i_rvalid, d_rvalid = 0; i_rdata, d_rdata = 0.
  - Outputs remain combinational from state, so while reset is asserted gnt, ram_read and ram_write are all 0.
- Handshake:
  - A requester holds req high with a stable payload until it sees gnt.
  - gnt is combinational from the reqs and state, asserted only in ST_IDLE, and at most one gnt per cycle.
  - Dropping req before gnt is legal and simply withdraws the request.
- Arbitration (ST_IDLE):
  - Only one req: that port wins.
  - Both reqs: the port not equal to last_grant wins, i.e. strict alternation under contention; after reset, fetch wins first.
  - last_grant updates on every grant.
- RAM drive:
  - In the grant cycle, ram_address, ram_writedata, ram_write (=d_we for data, 0 for fetch) and ram_read (=!write) come from the winning port.
  - No grant: ram_read=0, ram_write=0; address and writedata hold their last granted values (registered copy).
- Writes:
  - The RAM commits at the end of the grant cycle.
  - No rvalid is produced.
  - Throughput is one per cycle at both latencies.
- Reads, READ_LATENCY=0:
  - Grant in cycle N; at the end of N, the port rdata register <= ram_readdata and its rvalid <= 1.
  - rvalid is high in N+1 only.
  - A new grant is allowed in N+1 (one read per cycle).
- Reads, READ_LATENCY=1:
  - Grant in N; state -> ST_WAIT.
  - In N+1: no grants, ram_read=0, ram_write=0, address held.
  - At the end of N+1: capture ram_readdata, pulse rvalid, state -> ST_IDLE.
  - rvalid is high in N+2; grants resume in N+2.
- Response routing uses a registered pending_port captured at grant.
- rdata holds its value until the next read response on the same port. The other port's rdata is never disturbed.
- rvalid is never asserted for both ports in the same cycle.
- Reset while in ST_WAIT: the pending read is dropped, no rvalid is generated, and the FSM is back in ST_IDLE on release. RAM contents are unaffected except for writes whose edge completed before reset.
- Address wrap: 12-bit, no range checks; 0xFFF is a valid location.

Decomposition:
- Package mu0_mem_pkg:
  - ADDR_W=12, DATA_W=16.
  - typedef enum port_t {PORT_FETCH, PORT_DATA}.
  - typedef enum state_t {ST_IDLE, ST_WAIT}.
- One natural sub-module: mu0_rr_arb2, a 2-way round-robin grant with last_grant register, enable input (high in ST_IDLE) and update-on-grant.
- FSM, RAM muxing and response registers stay in the top.

Test Plan:
- Reset: rst_n=0 with i_req=d_req=1 -> i_gnt=d_gnt=0, ram_read=ram_write=0, both rvalid=0, both rdata=0x0000; rst_n released -> first grant is fetch.
- READ_LATENCY=0, mem[0x010]=0x1234, i_req addr 0x010 in cycle N -> i_gnt=1 and ram_read=1, ram_address=0x010 in N; i_rvalid=1 and i_rdata=0x1234 in N+1; i_rdata still 0x1234 at N+5.
- READ_LATENCY=0, both ports requesting reads continuously for 6 cycles -> grants F,D,F,D,F,D; each rvalid follows its grant by one cycle; never both rvalid high together.
- Data write d_we=1, addr 0xFFF, wdata 0xBEEF -> d_gnt same cycle, ram_write=1, no d_rvalid; then fetch read 0xFFF -> i_rdata=0xBEEF.
- READ_LATENCY=1, d read 0x020 (mem=0xA5A5) in N with i_req held -> no gnt in N+1; d_rvalid=1, d_rdata=0xA5A5 in N+2; i_gnt=1 in N+2.
- READ_LATENCY=1, rst_n pulsed low during ST_WAIT -> no d_rvalid ever for that read, d_rdata=0; next i_req granted in its first cycle after release.
